// File: rtl/paddle_tracker.sv
// Paddle block: fires the 555 one-shot on each VSync, measures its pulse in
// scanlines, latches a clamped/inverted Y at frame start and draws the paddle.
// Ports: i_Clk/i_Reset_n clock and async reset; i_VSync/i_HReset/i_VReset raster
// timing; i_555_Output async one-shot output; o_555_Trigger one-shot trigger;
// o_Video registered paddle pixel; o_Paddle_Y/o_Y_Valid committed position.
module paddle_tracker #(
    parameter int p_PADDLE_HEIGHT  = 55,
    parameter int p_PADDLE_WIDTH   = 12,
    parameter int p_PADDLE_X       = 30,
    parameter int p_X_W            = 10,
    parameter int p_Y_W            = 10,
    parameter int p_Y_OFFSET       = 0,
    parameter int p_Y_MAX          = 424,
    parameter int p_TRIGGER_CYCLES = 4,
    parameter int p_INVERT         = 0
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    input  logic             i_VSync,
    input  logic             i_HReset,
    input  logic             i_VReset,
    input  logic             i_555_Output,
    output logic             o_555_Trigger,
    output logic             o_Video,
    output logic [p_Y_W-1:0] o_Paddle_Y,
    output logic             o_Y_Valid
);

    localparam int YW1  = p_Y_W + 1;
    localparam int XW1  = p_X_W + 1;
    localparam int TC_W = $clog2(p_TRIGGER_CYCLES + 1);
    localparam logic [p_Y_W-1:0] Y_SAT = '1;
    localparam logic [p_X_W-1:0] X_SAT = '1;

    typedef enum logic [1:0] {IDLE, TRIG, MEASURE, DONE} state_t;

    state_t            state, state_nxt;
    logic              sync1, s555, s555_d, vsync_d;
    logic [TC_W-1:0]   tcnt;
    logic [p_Y_W-1:0]  meas, y_new, ly;
    logic [p_X_W-1:0]  dx;
    logic              pending;
    logic              trig_start;

    wire vs_rise   = i_VSync & ~vsync_d;
    wire s555_fall = s555_d & ~s555;

    // 2-FF synchroniser plus one more stage for fall detection.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sync1   <= 1'b0;
            s555    <= 1'b0;
            s555_d  <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            sync1   <= i_555_Output;
            s555    <= sync1;
            s555_d  <= s555;
            vsync_d <= i_VSync;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // A VSync rise in TRIG or MEASURE restarts the trigger (abort).
    always_comb begin
        state_nxt  = state;
        trig_start = 1'b0;
        case (state)
            IDLE: begin
                if (vs_rise) begin
                    state_nxt  = TRIG;
                    trig_start = 1'b1;
                end
            end
            TRIG: begin
                if (vs_rise) begin
                    state_nxt  = TRIG;
                    trig_start = 1'b1;
                end else if (tcnt == TC_W'(p_TRIGGER_CYCLES - 1)) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (vs_rise) begin
                    state_nxt  = TRIG;
                    trig_start = 1'b1;
                end else if (s555_fall || meas == Y_SAT) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_555_Trigger = (state == TRIG);

    // s555_d keeps the line that coincides with the fall in the count.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            tcnt <= '0;
            meas <= '0;
        end else begin
            if (trig_start)          tcnt <= '0;
            else if (state == TRIG)  tcnt <= tcnt + TC_W'(1);
            if (trig_start)
                meas <= '0;
            else if (state == MEASURE && i_HReset && (s555 || s555_d) && meas != Y_SAT)
                meas <= meas + 1'b1;
        end
    end

    // Position arithmetic, one bit wider than the line counter.
    logic [YW1-1:0] m_ext, t_val, y_val;
    always_comb begin
        m_ext = {1'b0, meas};
        if (m_ext < YW1'(p_Y_OFFSET)) t_val = '0;
        else                          t_val = m_ext - YW1'(p_Y_OFFSET);
        if (t_val > YW1'(p_Y_MAX))    t_val = YW1'(p_Y_MAX);
        if (p_INVERT != 0)            y_val = YW1'(p_Y_MAX) - t_val;
        else                          y_val = t_val;
    end

    // A DONE coinciding with VReset commits the older pending value (if any);
    // the fresh result waits for the next frame.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            y_new      <= '0;
            pending    <= 1'b0;
            o_Paddle_Y <= '0;
            o_Y_Valid  <= 1'b0;
        end else begin
            if (i_VReset && pending) begin
                o_Paddle_Y <= y_new;
                o_Y_Valid  <= 1'b1;
            end
            if (state == DONE) begin
                y_new   <= y_val[p_Y_W-1:0];
                pending <= 1'b1;
            end else if (i_VReset) begin
                pending <= 1'b0;
            end
        end
    end

    // Raster counters and registered paddle pixel.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            ly      <= '0;
            dx      <= '0;
            o_Video <= 1'b0;
        end else begin
            if (i_VReset)                    ly <= '0;
            else if (i_HReset && ly != Y_SAT) ly <= ly + 1'b1;
            if (i_HReset)                    dx <= '0;
            else if (dx != X_SAT)            dx <= dx + 1'b1;
            o_Video <= o_Y_Valid
                && ({1'b0, ly} >= {1'b0, o_Paddle_Y})
                && ({1'b0, ly} <  {1'b0, o_Paddle_Y} + YW1'(p_PADDLE_HEIGHT))
                && ({1'b0, dx} >= XW1'(p_PADDLE_X))
                && ({1'b0, dx} <  XW1'(p_PADDLE_X + p_PADDLE_WIDTH));
        end
    end

endmodule

// File: tb/tb_paddle_tracker.sv
// Directed bench for paddle_tracker: three instances (default, offset 20,
// inverted) share stimulus; expected positions are hand-computed constants.
module tb_paddle_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, vsync, hreset, vreset, o555;
    logic trig0, vid0, val0, trig1, vid1, val1, trig2, vid2, val2;
    logic [9:0] y0, y1, y2;

    int vecs = 0;
    int errs = 0;

    paddle_tracker dut0 (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_VSync(vsync), .i_HReset(hreset),
        .i_VReset(vreset), .i_555_Output(o555), .o_555_Trigger(trig0),
        .o_Video(vid0), .o_Paddle_Y(y0), .o_Y_Valid(val0));

    paddle_tracker #(.p_Y_OFFSET(20)) dut1 (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_VSync(vsync), .i_HReset(hreset),
        .i_VReset(vreset), .i_555_Output(o555), .o_555_Trigger(trig1),
        .o_Video(vid1), .o_Paddle_Y(y1), .o_Y_Valid(val1));

    paddle_tracker #(.p_INVERT(1)) dut2 (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_VSync(vsync), .i_HReset(hreset),
        .i_VReset(vreset), .i_555_Output(o555), .o_555_Trigger(trig2),
        .o_Video(vid2), .o_Paddle_Y(y2), .o_Y_Valid(val2));

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic line(input int len);
        hreset = 1'b1;
        cyc(1);
        hreset = 1'b0;
        cyc(len - 1);
    endtask

    task automatic commit();
        vreset = 1'b1;
        cyc(1);
        vreset = 1'b0;
    endtask

    // bit k = trigger level sampled k+1 clocks after the rising VSync edge
    task automatic vsync_rise(output logic [5:0] mask);
        vsync = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            mask[k] = trig0;
            if (k == 1) vsync = 1'b0;
        end
    endtask

    task automatic measure(input int n, input bit drop, output logic [5:0] mask);
        vsync_rise(mask);
        o555 = 1'b1;
        cyc(3);
        repeat (n) line(4);
        if (drop) begin
            o555 = 1'b0;
            cyc(6);
        end
    endtask

    logic [5:0] mask;
    int cnt, first, tcount;

    initial begin
        rst_n = 1'b0; vsync = 1'b0; hreset = 1'b0; vreset = 1'b0; o555 = 1'b0;
        cyc(3);
        check("rst_y", 32'(y0), 32'd0);
        check("rst_valid", 32'(val0), 32'd0);
        check("rst_trig", 32'(trig0), 32'd0);
        check("rst_video", 32'(vid0), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // basic 100-line measurement
        measure(100, 1'b1, mask);
        check("trig_shape", 32'(mask), 32'h0F);
        check("pre_commit_valid", 32'(val0), 32'd0);
        commit();
        check("y100_d0", 32'(y0), 32'd100);
        check("valid_d0", 32'(val0), 32'd1);
        check("y100_off20", 32'(y1), 32'd80);
        check("y100_inv", 32'(y2), 32'd324);

        // one frame of 50-clock lines; VReset shares the first HReset
        for (int ln = 0; ln < 156; ln++) begin
            hreset = 1'b1;
            if (ln == 0) vreset = 1'b1;
            cyc(1);
            hreset = 1'b0;
            vreset = 1'b0;
            cnt = 0;
            first = -1;
            for (int j = 1; j < 50; j++) begin
                cyc(1);
                if (vid0) begin
                    cnt++;
                    if (first < 0) first = j;
                end
            end
            if (ln == 99)  check("vid_line99", 32'(cnt), 32'd0);
            if (ln == 100) begin
                check("vid_line100_cnt", 32'(cnt), 32'd12);
                check("vid_line100_start", 32'(first), 32'd31);
            end
            if (ln == 154) check("vid_line154_cnt", 32'(cnt), 32'd12);
            if (ln == 155) check("vid_line155", 32'(cnt), 32'd0);
        end

        // small measurement: offset floors at zero, inversion from max
        measure(10, 1'b1, mask);
        commit();
        check("y10_d0", 32'(y0), 32'd10);
        check("y10_off20", 32'(y1), 32'd0);
        check("y10_inv", 32'(y2), 32'd414);

        // large measurement clamps
        measure(600, 1'b1, mask);
        commit();
        check("y600_d0", 32'(y0), 32'd424);
        check("y600_off20", 32'(y1), 32'd424);
        check("y600_inv", 32'(y2), 32'd0);

        // stuck-high one-shot: counter saturates and finishes on its own
        measure(1030, 1'b1, mask);
        commit();
        check("timeout_d0", 32'(y0), 32'd424);
        check("timeout_inv", 32'(y2), 32'd0);

        // abort during MEASURE: fresh 4-clock trigger, position kept
        measure(50, 1'b0, mask);
        vsync_rise(mask);
        check("abort_trig_shape", 32'(mask), 32'h0F);
        commit();
        check("abort_y_hold", 32'(y0), 32'd424);
        repeat (20) line(4);
        o555 = 1'b0;
        cyc(6);
        commit();
        check("after_abort_d0", 32'(y0), 32'd20);
        check("after_abort_inv", 32'(y2), 32'd404);

        // DONE in the same clock as VReset: no update until next frame
        measure(77, 1'b0, mask);
        o555 = 1'b0;
        cyc(3);
        vreset = 1'b1;
        cyc(1);
        vreset = 1'b0;
        check("no_tear_hold", 32'(y0), 32'd20);
        cyc(5);
        check("no_tear_still", 32'(y0), 32'd20);
        commit();
        check("no_tear_d0", 32'(y0), 32'd77);
        check("no_tear_off20", 32'(y1), 32'd57);
        check("no_tear_inv", 32'(y2), 32'd347);

        // reset in the middle of MEASURE
        vsync_rise(mask);
        o555 = 1'b1;
        cyc(3);
        repeat (10) line(4);
        rst_n = 1'b0;
        cyc(1);
        check("midrst_y", 32'(y0), 32'd0);
        check("midrst_valid", 32'(val0), 32'd0);
        check("midrst_trig", 32'(trig0), 32'd0);
        check("midrst_video", 32'(vid0), 32'd0);
        check("midrst_valid_inv", 32'(val2), 32'd0);
        o555 = 1'b0;
        rst_n = 1'b1;
        tcount = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            if (trig0) tcount++;
        end
        check("post_rst_no_trig", 32'(tcount), 32'd0);
        vsync_rise(mask);
        check("post_rst_trig_shape", 32'(mask), 32'h0F);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
